// File: rtl/nbbpu_controller.sv
// NBBPU multi-cycle sequencer: fetch, decode, execute and memory phases
// driving the datapath strobes from the state and the IR opcode.
module nbbpu_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        mem_ready,
  input  logic        x_zero,
  input  logic        x_negative,
  output logic        instr_req,
  output logic        ir_load,
  output logic        data_read,
  output logic        data_write,
  output logic        reg_write_lower,
  output logic        reg_write_upper,
  output logic        reg_set,
  output logic        PC_select,
  output logic        pc_enable,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, HALTED, FAULT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST =
    COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]             op;
  logic                   is_alu, is_jmp, is_brz, is_brn;
  logic                   is_hlt, is_lod, is_str, is_sel, is_seu;
  logic                   timeout;

  assign op      = instruction[15:12];
  assign is_alu  = ~op[3];
  assign is_jmp  = (op == 4'h8);
  assign is_brz  = (op == 4'h9);
  assign is_brn  = (op == 4'hA);
  assign is_hlt  = (op == 4'hB);
  assign is_lod  = (op == 4'hC);
  assign is_str  = (op == 4'hD);
  assign is_sel  = (op == 4'hE);
  assign is_seu  = (op == 4'hF);
  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    instr_req       = 1'b0;
    ir_load         = 1'b0;
    data_read       = 1'b0;
    data_write      = 1'b0;
    reg_write_lower = 1'b0;
    reg_write_upper = 1'b0;
    reg_set         = 1'b0;
    PC_select       = 1'b0;
    pc_enable       = 1'b0;
    halted          = 1'b0;
    fault           = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        instr_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = FAULT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        state_d = FETCH;
        cnt_d   = '0;
        unique case (1'b1)
          is_alu: begin
            reg_write_lower = 1'b1;
            reg_write_upper = 1'b1;
            pc_enable       = 1'b1;
          end
          is_sel: begin
            reg_set         = 1'b1;
            reg_write_lower = 1'b1;
            pc_enable       = 1'b1;
          end
          is_seu: begin
            reg_set         = 1'b1;
            reg_write_upper = 1'b1;
            pc_enable       = 1'b1;
          end
          is_jmp: begin
            pc_enable = 1'b1;
            PC_select = 1'b1;
          end
          is_brz: begin
            pc_enable = 1'b1;
            PC_select = x_zero;
          end
          is_brn: begin
            pc_enable = 1'b1;
            PC_select = x_negative;
          end
          is_hlt: state_d = HALTED;
          is_lod, is_str: state_d = MEMORY;
          default: ;
        endcase
      end
      MEMORY: begin
        data_read  = is_lod;
        data_write = is_str;
        if (mem_ready) begin
          reg_write_lower = is_lod;
          reg_write_upper = is_lod;
          pc_enable       = 1'b1;
          state_d         = FETCH;
          cnt_d           = '0;
        end else if (timeout) begin
          state_d = FAULT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HALTED: halted = 1'b1;
      FAULT:  fault  = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nbbpu_controller.sv
// Directed bench for nbbpu_controller; expected output vectors queue up
// as each cycle's stimulus is driven and are checked at the falling edge.
module tb_nbbpu_controller;

  localparam logic [10:0] IREQ = 11'b100_0000_0000;
  localparam logic [10:0] IRLD = 11'b010_0000_0000;
  localparam logic [10:0] DRD  = 11'b001_0000_0000;
  localparam logic [10:0] DWR  = 11'b000_1000_0000;
  localparam logic [10:0] RWL  = 11'b000_0100_0000;
  localparam logic [10:0] RWU  = 11'b000_0010_0000;
  localparam logic [10:0] RSET = 11'b000_0001_0000;
  localparam logic [10:0] PSEL = 11'b000_0000_1000;
  localparam logic [10:0] PCEN = 11'b000_0000_0100;
  localparam logic [10:0] HLT  = 11'b000_0000_0010;
  localparam logic [10:0] FLT  = 11'b000_0000_0001;
  localparam logic [10:0] NONE = 11'b0;

  logic        clock;
  logic        reset;
  logic [15:0] instruction;
  logic        mem_ready;
  logic        x_zero;
  logic        x_negative;
  logic        instr_req, ir_load, data_read, data_write;
  logic        reg_write_lower, reg_write_upper, reg_set;
  logic        PC_select, pc_enable, halted, fault;
  logic [10:0] obs;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  nbbpu_controller #(
    .TIMEOUT_CYCLES(16),
    .COUNT_WIDTH   (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .instruction    (instruction),
    .mem_ready      (mem_ready),
    .x_zero         (x_zero),
    .x_negative     (x_negative),
    .instr_req      (instr_req),
    .ir_load        (ir_load),
    .data_read      (data_read),
    .data_write     (data_write),
    .reg_write_lower(reg_write_lower),
    .reg_write_upper(reg_write_upper),
    .reg_set        (reg_set),
    .PC_select      (PC_select),
    .pc_enable      (pc_enable),
    .halted         (halted),
    .fault          (fault)
  );

  assign obs = {instr_req, ir_load, data_read, data_write,
                reg_write_lower, reg_write_upper, reg_set,
                PC_select, pc_enable, halted, fault};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Check this cycle's outputs at the falling edge, then move past
  // the next rising edge.
  task automatic chk(input string tag, input logic [10:0] e);
    logic [10:0] ex;
    string       tg;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    ex = exp_q.pop_front();
    tg = tag_q.pop_front();
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tg, obs, ex);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ins,
                           input logic [10:0] ex_exec,
                           input string tag);
    instruction = ins;
    mem_ready   = 1'b1;
    chk({tag, "_fetch"}, IREQ | IRLD);
    chk({tag, "_decode"}, NONE);
    chk({tag, "_exec"}, ex_exec);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_rst"}, NONE);
    reset = 1'b1;
    chk({tag, "_idle"}, NONE);
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 16'h0123;
    mem_ready   = 1'b1;
    x_zero      = 1'b0;
    x_negative  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset("init");

    run_instr(16'h0123, RWL | RWU | PCEN, "add");
    run_instr(16'hE5A3, RSET | RWL | PCEN, "sel");
    run_instr(16'hF5A3, RSET | RWU | PCEN, "seu");
    x_zero = 1'b0;
    run_instr(16'h9300, PCEN, "brz_nt");
    x_zero = 1'b1;
    run_instr(16'h9300, PCEN | PSEL, "brz_t");
    x_zero     = 1'b0;
    x_negative = 1'b1;
    run_instr(16'hA000, PCEN | PSEL, "brn_t");
    x_negative = 1'b0;
    run_instr(16'hA000, PCEN, "brn_nt");
    run_instr(16'h8000, PCEN | PSEL, "jmp");

    instruction = 16'hC120;
    mem_ready   = 1'b1;
    chk("lod_fetch", IREQ | IRLD);
    mem_ready = 1'b0;
    chk("lod_decode", NONE);
    chk("lod_exec", NONE);
    for (int i = 0; i < 3; i++) chk("lod_wait", DRD);
    mem_ready = 1'b1;
    chk("lod_done", DRD | RWL | RWU | PCEN);

    instruction = 16'hD120;
    chk("str_fetch", IREQ | IRLD);
    chk("str_decode", NONE);
    chk("str_exec", NONE);
    chk("str_done", DWR | PCEN);

    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) chk("to_wait", IREQ);
    chk("to_fault", FLT);
    mem_ready = 1'b1;
    chk("fault_hold1", FLT);
    chk("fault_hold2", FLT);

    do_reset("post_fault");
    run_instr(16'h0123, RWL | RWU | PCEN, "add2");

    run_instr(16'hBFFF, NONE, "halt");
    for (int i = 0; i < 3; i++) chk("halted", HLT);

    do_reset("post_halt");
    instruction = 16'hC120;
    mem_ready   = 1'b1;
    chk("lod2_fetch", IREQ | IRLD);
    mem_ready = 1'b0;
    chk("lod2_decode", NONE);
    chk("lod2_exec", NONE);
    chk("lod2_mem", DRD);
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    chk("lod2_abort", NONE);
    reset = 1'b1;
    chk("lod2_idle", NONE);
    run_instr(16'h0123, RWL | RWU | PCEN, "add3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nbbpu_controller.md
Name: nbbpu_controller

Overview:
Multi-cycle control sequencer for the NBBPU datapath. It fetches each instruction over a ready/request memory handshake and latches it into the instruction register. It then decodes the 4-bit opcode and drives the datapath strobes (reg_write_lower, reg_write_upper, reg_set, PC_select, PC enable) and the data-memory request lines. It sits between the memory interface and the datapath, with one instruction in flight at a time.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory request may wait for mem_ready before FAULT (legal range 1..255)
COUNT_WIDTH, 8, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; one clock domain only
instruction  input  16  instruction register contents, valid the cycle after ir_load
mem_ready  input  1  memory completes the current request this cycle
x_zero  input  1  datapath flag: register x == 0
x_negative  input  1  datapath flag: register x bit 15 set
instr_req  output  1  instruction fetch request at PC
ir_load  output  1  latch the instruction bus into the IR at the next edge
data_read  output  1  data-memory read request (LOD)
data_write  output  1  data-memory write request (STR)
reg_write_lower  output  1  write regfile byte [7:0]
reg_write_upper  output  1  write regfile byte [15:8]
reg_set  output  1  select the immediate byte as regfile input
PC_select  output  1  0 = PC+2, 1 = jump target
pc_enable  output  1  update PC at the next edge
halted  output  1  HALT executed
fault  output  1  memory timeout occurred

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, HALTED, FAULT. The state register and wait counter are the only flops; all outputs decode from the state and the IR opcode.
- Reset (reset = 0, asynchronous): state = IDLE, counter = 0. All outputs are 0 while reset is low and in IDLE. IDLE -> FETCH on the first edge after reset releases.
- FETCH:
  - instr_req = 1.
  - When mem_ready = 1: ir_load = 1 in the same cycle, then -> DECODE.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 with no ready -> FAULT.
- DECODE: one cycle with no strobes. The IR is stable. -> EXECUTE.
- Opcode map (instruction[15:12]):
  - 0x0-0x7: ALU ops.
  - 0x8: JMP.
  - 0x9: BRZ.
  - 0xA: BRN.
  - 0xB: HALT.
  - 0xC: LOD.
  - 0xD: STR.
  - 0xE: SEL.
  - 0xF: SEU.
- EXECUTE (one cycle, then -> FETCH unless stated otherwise):
  - ALU ops: reg_write_lower = reg_write_upper = 1, pc_enable = 1, PC_select = 0.
  - SEL: reg_set = 1, reg_write_lower = 1, pc_enable = 1.
  - SEU: reg_set = 1, reg_write_upper = 1, pc_enable = 1.
  - JMP: pc_enable = 1, PC_select = 1.
  - BRZ: pc_enable = 1, PC_select = x_zero.
  - BRN: pc_enable = 1, PC_select = x_negative.
  - HALT: no strobes, -> HALTED.
  - LOD/STR: no strobes, counter cleared, -> MEMORY.
- MEMORY:
  - data_read = 1 (LOD) or data_write = 1 (STR).
  - On mem_ready:
    - LOD: reg_write_lower = reg_write_upper = 1 and pc_enable = 1 in the same cycle.
    - STR: pc_enable = 1.
    - Then -> FETCH.
  - The timeout rule is the same as in FETCH.
- Latency with mem_ready tied high: ALU/SET/branch = 3 cycles; LOD/STR = 4 cycles.
- The counter clears on every entry to FETCH or MEMORY. It saturates and never wraps.
- mem_ready while no request is active (DECODE, EXECUTE, IDLE, HALTED) is ignored.
- At most one of instr_req, data_read, data_write is high at any time.
- HALTED: halted = 1, all other outputs 0. Exit only by reset.
- FAULT: fault = 1, all other outputs 0. Exit only by reset.
- Reset asserted mid-request (any state): outputs drop to 0 immediately (asynchronous). The request is abandoned and execution restarts at IDLE.
- The x_zero and x_negative flags are sampled only in EXECUTE for BRZ/BRN.

Test Plan:
- Reset, mem_ready = 1, instruction = 0x0123 (ADD) -> IDLE, FETCH (instr_req, ir_load), DECODE, EXECUTE with reg_write_lower/upper = 1, pc_enable = 1, PC_select = 0; next instr_req 4 cycles after reset release.
- instruction = 0xE5A3 (SEL) then 0xF5A3 (SEU) -> reg_set = 1 with only lower, then only upper, write strobe high for exactly one cycle each.
- BRZ 0x9300 with x_zero = 0, then x_zero = 1 -> PC_select 0 then 1, pc_enable = 1 both times; JMP 0x8000 -> PC_select = 1.
- LOD 0xC120 with mem_ready low 3 cycles in MEMORY -> data_read held 4 cycles, then reg writes + pc_enable on the ready cycle; STR 0xD120 -> data_write only, no reg writes.
- mem_ready held low in FETCH for TIMEOUT_CYCLES (16) -> fault = 1 after 16 request cycles, all strobes 0; fault persists until reset, then normal fetch resumes.
- HALT 0xBFFF -> halted = 1, no further requests despite mem_ready = 1; reset pulsed low mid-MEMORY of a LOD -> data_read drops asynchronously and no reg write occurs.
